multicycle_controller: RTL

Multi-cycle control FSM for the RV32I core, replacing single-cycle opcode decoding with a sequenced fetch/decode/execute/memory/writeback flow. It sits between the instruction register and the datapath muxes. It handshakes with a shared, variable-latency memory port. It adds three behaviours the single-cycle core lacks: bus-timeout and illegal-opcode traps, and a retired-instruction counter.

---
 rtl/multicycle_controller_if.sv | 12 +
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Memory-port bundle between the multi-cycle controller and the shared memory.
// The master raises mem_req and holds it, along with mem_we and addr_sel, until it
// sees mem_ready. The transfer completes in that cycle.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// illegal-opcode and bus-timeout traps, and a retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_controller_if.master mem,
    input  logic [31:0]          instr_i,
    input  logic                 branch_taken_i,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic                 reg_we_o,
    output logic [1:0]           rd_src_o,
    output logic [1:0]           op1_sel_o,
    output logic [1:0]           op2_sel_o,
    output logic [2:0]           imm_sel_o,
    output logic [1:0]           alu_sub_sel_o,
    output logic [2:0]           state_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic [CNT_W-1:0]     instret_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         cause_q, cause_d;
    logic [CNT_W-1:0]   instret_q;
    logic               retire;
    logic               timeout_hit;
    logic               mem_req, mem_we, addr_sel;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift, is_cmp, legal;
    logic       unused_instr_bits;

    assign opcode            = instr_i[6:0];
    assign funct3            = instr_i[14:12];
    assign unused_instr_bits = ^{instr_i[31:15], instr_i[11:7]};
    assign is_shift          = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign is_cmp            = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign legal = (opcode == OP_LUI)    || (opcode == OP_AUIPC) || (opcode == OP_JAL)   ||
                   (opcode == OP_JALR)   || (opcode == OP_BRANCH) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE)  || (opcode == OP_IMM)   || (opcode == OP_REG);

    // This wait cycle would be the TIMEOUT-th consecutive one without mem_ready.
    assign timeout_hit = (TIMEOUT != 0) && ((int'(wait_q) + 1) == TIMEOUT);

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        wait_d        = wait_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = 2'b00;
        reg_we_o      = 1'b0;
        rd_src_o      = 2'b00;
        op1_sel_o     = 2'b00;
        op2_sel_o     = 2'b00;
        imm_sel_o     = 3'b000;
        alu_sub_sel_o = 2'b00;
        trap_o        = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) state_d = S_EXEC;
                else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_LUI:   begin op1_sel_o = 2'b10; op2_sel_o = 2'b10; imm_sel_o = 3'b010; end
                    OP_AUIPC: begin op1_sel_o = 2'b01; op2_sel_o = 2'b10; imm_sel_o = 3'b010; end
                    OP_JAL:   begin op1_sel_o = 2'b01; op2_sel_o = 2'b10; imm_sel_o = 3'b001; end
                    OP_JALR:  op2_sel_o = 2'b10;
                    OP_BRANCH: begin
                        imm_sel_o = 3'b100;
                        pc_we_o   = 1'b1;
                        pc_sel_o  = branch_taken_i ? 2'b01 : 2'b00;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_LOAD:  begin op2_sel_o = 2'b10; state_d = S_MEM; end
                    OP_STORE: begin op2_sel_o = 2'b10; imm_sel_o = 3'b101; state_d = S_MEM; end
                    OP_IMM: begin
                        op2_sel_o     = 2'b10;
                        imm_sel_o     = is_shift ? 3'b011 : 3'b000;
                        alu_sub_sel_o = is_cmp ? 2'b01 : (is_shift ? 2'b10 : 2'b00);
                    end
                    OP_REG: alu_sub_sel_o = is_cmp ? 2'b01 : (is_shift ? 2'b10 : 2'b00);
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem.mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_WB: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                if (opcode == OP_LOAD) rd_src_o = 2'b01;
                else if ((opcode == OP_JAL) || (opcode == OP_JALR)) rd_src_o = 2'b10;
                if (opcode == OP_JAL) pc_sel_o = 2'b01;
                else if (opcode == OP_JALR) pc_sel_o = 2'b10;
            end
            S_TRAP: trap_o = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
            wait_d = '0;
        else if (mem_req && !mem.mem_ready && (wait_q != '1))
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            cause_q   <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_we;
    assign mem.addr_sel  = addr_sel;
    assign state_o       = state_q;
    assign trap_cause_o  = cause_q;
    assign instret_o     = instret_q;
endmodule
